// File: rtl/sample_stream_buffer.sv
// Ready/valid stream buffer: first-word-fall-through FIFO with occupancy flags and flush.
// Define SAMPLE_STREAM_BUFFER_STATS_EN to add saturating push/pop/stall counters.
module sample_stream_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stream_in_valid,
    output logic                         stream_in_ready,
    input  logic [DATA_WIDTH-1:0]        stream_in_data,
    output logic                         stream_out_valid,
    input  logic                         stream_out_ready,
    output logic [DATA_WIDTH-1:0]        stream_out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
    output logic [CNT_WIDTH-1:0]         in_count,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic [CNT_WIDTH-1:0]         stall_count,
`endif
    output logic                         empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_WIDTH < 1 || CNT_WIDTH < 1)
    begin : gen_param_check
        $error("sample_stream_buffer: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  push, pop;

    assign full             = (level_q == LvlW'(DEPTH));
    assign empty            = (level_q == '0);
    assign level            = level_q;
    assign stream_in_ready  = !full && !reset && !flush;
    assign stream_out_valid = !empty;
    assign stream_out_data  = mem_q[rd_ptr_q];

    assign push = stream_in_valid && stream_in_ready;
    assign pop  = stream_out_valid && stream_out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; push already excludes reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= stream_in_data;
    end

`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
    logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && in_cnt_q != '1) in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
        // A pop coinciding with flush is discarded, so it is not counted.
        if (pop && !flush && out_cnt_q != '1) out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
        if (stream_out_valid && !stream_out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_count    = in_cnt_q;
    assign out_count   = out_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sample_stream_buffer.sv
// Self-checking bench for sample_stream_buffer: queue model checked every cycle plus
// directed literal expectations.
module tb_sample_stream_buffer;

    localparam int unsigned DW   = 8;
    localparam int unsigned DEP  = 4;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [2:0]    level;
    logic          full, empty;
`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
    logic [CW-1:0] in_count, out_count, stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    sample_stream_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stream_in_valid (in_valid),
        .stream_in_ready (in_ready),
        .stream_in_data  (in_data),
        .stream_out_valid(out_valid),
        .stream_out_ready(out_ready),
        .stream_out_data (out_data),
        .flush           (flush),
        .level           (level),
        .full            (full),
`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
        .in_count        (in_count),
        .out_count       (out_count),
        .stall_count     (stall_count),
`endif
        .empty           (empty)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded queue plus saturating counters.
    logic [DW-1:0] mq[$];
    bit            model_on = 0;
    int            m_in = 0, m_out = 0, m_stall = 0;

    always @(posedge clk) begin
        bit do_push, do_pop, do_stall;
        do_push  = in_valid && !reset && !flush && (mq.size() < DEP);
        do_pop   = (mq.size() > 0) && out_ready;
        do_stall = (mq.size() > 0) && !out_ready;
        if (reset) begin
            mq.delete();
            m_in = 0; m_out = 0; m_stall = 0;
            model_on = 1;
        end else begin
            if (do_stall && m_stall < CMAX) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    void'(mq.pop_front());
                    if (m_out < CMAX) m_out++;
                end
                if (do_push) begin
                    mq.push_back(in_data);
                    if (m_in < CMAX) m_in++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            cmp("m_level", 32'(level), 32'(mq.size()));
            cmp("m_empty", 32'(empty), 32'(mq.size() == 0));
            cmp("m_full", 32'(full), 32'(mq.size() == DEP));
            cmp("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            cmp("m_in_ready", 32'(in_ready), 32'(!reset && !flush && mq.size() < DEP));
            if (mq.size() > 0) cmp("m_out_data", 32'(out_data), 32'(mq[0]));
`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
            cmp("m_in_count", 32'(in_count), 32'(m_in));
            cmp("m_out_count", 32'(out_count), 32'(m_out));
            cmp("m_stall_count", 32'(stall_count), 32'(m_stall));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] drain [4];
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset held for two cycles.
        tick(); #1 cmp("rst_ready_c1", 32'(in_ready), 0);
        tick(); #1;
        cmp("rst_ready_c2", 32'(in_ready), 0);
        cmp("rst_level", 32'(level), 0);
        cmp("rst_empty", 32'(empty), 1);
        cmp("rst_full", 32'(full), 0);
        cmp("rst_valid", 32'(out_valid), 0);
        reset = 1'b0;
        #1 cmp("post_rst_ready", 32'(in_ready), 1);

        // Fill with sink stalled; fifth beat must be refused.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        in_data = 8'h55;
        #1;
        cmp("fill_full", 32'(full), 1);
        cmp("fill_level", 32'(level), 4);
        cmp("fill_ready", 32'(in_ready), 0);
        cmp("fill_head", 32'(out_data), 32'h11);
        tick(); #1;
        cmp("hold_head", 32'(out_data), 32'h11);
        cmp("hold_level", 32'(level), 4);

        // Drain; 0x55 enters on the cycle after full drops.
        out_ready = 1'b1;
        tick(); #1;
        cmp("drain1_ready", 32'(in_ready), 1);
        cmp("drain1_level", 32'(level), 3);
        tick();
        in_valid = 1'b0;
        drain[0] = 8'h33; drain[1] = 8'h44; drain[2] = 8'h55; drain[3] = 8'h00;
        #1 cmp("drain2_level", 32'(level), 3);
        for (int i = 0; i < 3; i++) begin
            cmp("drain_head", 32'(out_data), 32'(drain[i]));
            tick(); #1;
        end
        cmp("drain_empty", 32'(empty), 1);

        // Streaming with both sides ready, across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            tick(); #1;
            cmp("stream_head", 32'(out_data), 32'(k));
            cmp("stream_level", 32'(level), 1);
        end
        in_valid = 1'b0;
        tick(); #1 cmp("stream_empty", 32'(empty), 1);

        // Flush with three stored beats and a beat offered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA1 + i);
            tick();
        end
        in_data = 8'hEE; flush = 1'b1; out_ready = 1'b1;
        #1;
        cmp("flush_ready", 32'(in_ready), 0);
        cmp("flush_pre_level", 32'(level), 3);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        cmp("flush_level", 32'(level), 0);
        cmp("flush_valid", 32'(out_valid), 0);
        repeat (3) tick();
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        #1 cmp("post_flush_head", 32'(out_data), 32'h5A);
        tick(); #1 cmp("post_flush_empty", 32'(empty), 1);

        // Reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h61; tick();
        in_data = 8'h62; tick();
        reset = 1'b1; in_data = 8'h63;
        #1 cmp("midrst_ready", 32'(in_ready), 0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        cmp("midrst_level", 32'(level), 0);
        cmp("midrst_valid", 32'(out_valid), 0);

`ifdef SAMPLE_STREAM_BUFFER_STATS_EN
        // 5 pushes, 5 pops, 4 stalls with 2-bit counters.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        in_data = 8'h55;
        tick();
        out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1;
        cmp("stat_in", 32'(in_count), 3);
        cmp("stat_out", 32'(out_count), 3);
        cmp("stat_stall", 32'(stall_count), 3);
        flush = 1'b1; tick(); flush = 1'b0;
        #1;
        cmp("stat_flush_in", 32'(in_count), 3);
        cmp("stat_flush_stall", 32'(stall_count), 3);
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        cmp("stat_rst_in", 32'(in_count), 0);
        cmp("stat_rst_out", 32'(out_count), 0);
        cmp("stat_rst_stall", 32'(stall_count), 0);
`endif

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
